// File: rtl/data_port_pkg.sv
// Shared types, default widths and the round-robin search function for data_port_arbiter.
package data_port_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    // rr_next works on a fixed 16-wide space; unused requester slots are tied to zero.
    localparam int unsigned MAX_REQ  = 16;
    localparam int unsigned RR_IDX_W = 4;

    // First set bit of mask scanning upward from last+1 with wrap-around.
    function automatic logic [RR_IDX_W-1:0] rr_next(input logic [RR_IDX_W-1:0] last,
                                                    input logic [MAX_REQ-1:0]  mask);
        logic [RR_IDX_W-1:0] idx;
        rr_next = last;
        // Walk from the farthest candidate to the nearest so the nearest hit wins.
        for (int k = MAX_REQ; k >= 1; k--) begin
            idx = last + RR_IDX_W'(k);
            if (mask[idx]) begin
                rr_next = idx;
            end
        end
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: picks the next requester after last_grant.
module rr_picker
    import data_port_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [NUM_REQ-1:0]         winner,
    output logic [$clog2(NUM_REQ)-1:0] winner_idx,
    output logic                       any
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [RR_IDX_W-1:0] pick;
    logic                unused_pick;

    assign pick        = rr_next(RR_IDX_W'(last_grant), MAX_REQ'(req_valid));
    assign any         = |req_valid;
    assign winner_idx  = IDX_W'(pick);
    assign winner      = any ? (NUM_REQ'(1) << winner_idx) : '0;
    assign unused_pick = ^pick;

endmodule

// File: rtl/data_port_arbiter.sv
// Shares one get_data read unit between NUM_REQ requesters: round-robin grant,
// single-word fetch over the callee handshake, response routed back to the owner.
module data_port_arbiter
    import data_port_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                        _clock,
    input  logic                        _reset_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    output logic [NUM_REQ-1:0]          resp_valid,
    input  logic [NUM_REQ-1:0]          resp_ready,
    output logic signed [DATA_W-1:0]    resp_data,
    output logic                        resp_err,
    output logic [$clog2(NUM_REQ)-1:0]  grant,
    output logic                        callee_start,
    output logic                        callee_reset,
    output logic signed [ADDR_W-1:0]    callee_addr,
    output logic                        callee_ready,
    input  logic                        callee_valid,
    input  logic                        callee_done,
    input  logic signed [DATA_W-1:0]    callee_out0
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit          TIMEOUT_EN = (TIMEOUT != 0);

    arb_state_t                 state_q, state_d;
    logic [IDX_W-1:0]           last_grant_q;
    logic [IDX_W-1:0]           grant_q;
    logic signed [ADDR_W-1:0]   addr_q;
    logic signed [DATA_W-1:0]   data_q;
    logic                       err_q;
    logic                       have_data_q;
    logic [CNT_W-1:0]           cnt_q;

    logic [NUM_REQ-1:0]         win_onehot;
    logic [IDX_W-1:0]           win_idx;
    logic                       any_req;
    logic                       timeout_now;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req_valid  (req_valid),
        .last_grant (last_grant_q),
        .winner     (win_onehot),
        .winner_idx (win_idx),
        .any        (any_req)
    );

    assign timeout_now = TIMEOUT_EN && (cnt_q == CNT_W'(TIMEOUT));

    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        req_ready    = '0;
        resp_valid   = '0;
        callee_start = 1'b0;
        callee_ready = 1'b0;
        callee_reset = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    req_ready = win_onehot;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                callee_start = 1'b1;
                state_d      = WAIT;
            end
            WAIT: begin
                callee_ready = 1'b1;
                // A done arriving on the timeout cycle still completes normally.
                if (callee_done) begin
                    state_d = RESP;
                end else if (timeout_now) begin
                    callee_reset = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                resp_valid = NUM_REQ'(1) << grant_q;
                if (resp_ready[grant_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            grant_q      <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            err_q        <= 1'b0;
            have_data_q  <= 1'b0;
            cnt_q        <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        addr_q  <= req_addr[win_idx*ADDR_W +: ADDR_W];
                        grant_q <= win_idx;
                    end
                end
                ISSUE: begin
                    have_data_q <= 1'b0;
                    cnt_q       <= '0;
                end
                WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (callee_valid && !have_data_q) begin
                        data_q      <= callee_out0;
                        have_data_q <= 1'b1;
                    end
                    if (callee_done) begin
                        err_q <= !have_data_q && !callee_valid;
                    end else if (timeout_now) begin
                        data_q <= '0;
                        err_q  <= 1'b1;
                    end
                end
                RESP: begin
                    // Drop the owner's context so an idle port shows all-zero outputs.
                    if (resp_ready[grant_q]) begin
                        last_grant_q <= grant_q;
                        grant_q      <= '0;
                        addr_q       <= '0;
                        data_q       <= '0;
                        err_q        <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign grant       = grant_q;
    assign callee_addr = addr_q;
    assign resp_data   = data_q;
    assign resp_err    = err_q;

endmodule

// File: tb/tb_data_port_arbiter.sv
// Directed bench for data_port_arbiter with a small behavioural get_data callee model.
module tb_data_port_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;
    localparam int IDX_W   = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NUM_REQ-1:0]        req_valid  = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_addr   = '0;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [NUM_REQ-1:0]        resp_ready = '0;
    logic signed [DATA_W-1:0]  resp_data;
    logic                      resp_err;
    logic [IDX_W-1:0]          grant;
    logic                      callee_start;
    logic                      callee_reset;
    logic signed [ADDR_W-1:0]  callee_addr;
    logic                      callee_ready;
    logic                      callee_valid = 1'b0;
    logic                      callee_done  = 1'b0;
    logic signed [DATA_W-1:0]  callee_out0  = '0;

    int checks = 0;
    int errors = 0;

    // 0: valid+done, 1: valid only, 2: done only, 3: silent, 4: valid then valid+done
    int                       model_mode  = 0;
    logic                     model_start = 1'b0;
    logic                     model_stage2 = 1'b0;
    logic signed [ADDR_W-1:0] model_addr  = '0;
    logic signed [ADDR_W-1:0] model_addr2 = '0;

    data_port_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        ._clock       (clk),
        ._reset_n     (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .resp_err     (resp_err),
        .grant        (grant),
        .callee_start (callee_start),
        .callee_reset (callee_reset),
        .callee_addr  (callee_addr),
        .callee_ready (callee_ready),
        .callee_valid (callee_valid),
        .callee_done  (callee_done),
        .callee_out0  (callee_out0)
    );

    // Callee answers in the cycle after the start pulse; response word is addr + 42069.
    always @(posedge clk) begin
        model_start = callee_start;
        model_addr  = callee_addr;
        #1;
        callee_valid = 1'b0;
        callee_done  = 1'b0;
        if (model_stage2) begin
            callee_valid = 1'b1;
            callee_done  = 1'b1;
            callee_out0  = model_addr2 + 1;
            model_stage2 = 1'b0;
        end
        if (model_start) begin
            case (model_mode)
                0: begin
                    callee_valid = 1'b1;
                    callee_done  = 1'b1;
                    callee_out0  = model_addr + 42069;
                end
                1: begin
                    callee_valid = 1'b1;
                    callee_out0  = model_addr + 42069;
                end
                2: callee_done = 1'b1;
                4: begin
                    callee_valid = 1'b1;
                    callee_out0  = model_addr + 42069;
                    model_addr2  = model_addr;
                    model_stage2 = 1'b1;
                end
                default: ;
            endcase
        end
    end

    task automatic wait_start(output int cycles, output bit seen);
        seen   = 1'b0;
        cycles = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (callee_start) begin
                seen   = 1'b1;
                cycles = c;
                break;
            end
        end
    endtask

    task automatic wait_resp(output int cycles, output bit seen);
        seen   = 1'b0;
        cycles = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (|resp_valid) begin
                seen   = 1'b1;
                cycles = c;
                break;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, callee_start, callee_ready, callee_reset, resp_err, grant}
            !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 0", {req_ready, resp_valid, callee_start,
                     callee_ready, callee_reset, resp_err, grant});
        end
        checks++;
        if (resp_data !== 0 || callee_addr !== 0) begin
            errors++;
            $display("FAIL reset_data: got data %0d addr %0d required 0", resp_data, callee_addr);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({req_ready, callee_start, callee_ready} !== '0) begin
            errors++;
            $display("FAIL idle_quiet: got %b required 0", {req_ready, callee_start, callee_ready});
        end
    endtask

    task automatic test_contention;
        int  c;
        bit  seen;
        int  exp;
        @(posedge clk); #1;
        model_mode = 0;
        resp_ready = 4'b1111;
        for (int i = 0; i < NUM_REQ; i++) req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(i * 10);
        req_valid = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            exp = n % NUM_REQ;
            wait_start(c, seen);
            checks++;
            if (!seen || c != 2) begin
                errors++;
                $display("FAIL cont_start_gap[%0d]: got seen=%0d cycles=%0d required 1/2", n, seen, c);
            end
            checks++;
            if (grant !== IDX_W'(exp) || callee_addr !== exp * 10) begin
                errors++;
                $display("FAIL cont_grant[%0d]: got grant %0d addr %0d required %0d addr %0d",
                         n, grant, callee_addr, exp, exp * 10);
            end
            wait_resp(c, seen);
            checks++;
            if (!seen || c != 2) begin
                errors++;
                $display("FAIL cont_resp_lat[%0d]: got seen=%0d cycles=%0d required 1/2", n, seen, c);
            end
            checks++;
            if (resp_valid !== NUM_REQ'(1 << exp) || resp_data !== exp * 10 + 42069 || resp_err) begin
                errors++;
                $display("FAIL cont_resp[%0d]: got valid %b data %0d err %0d required %b %0d 0", n,
                         resp_valid, resp_data, resp_err, NUM_REQ'(1 << exp), exp * 10 + 42069);
            end
            if (n == 4) req_valid = '0;
        end
        @(negedge clk);
        checks++;
        if (req_ready !== '0 || resp_valid !== '0 || callee_start) begin
            errors++;
            $display("FAIL cont_idle: got ready %b valid %b start %0d required 0", req_ready,
                     resp_valid, callee_start);
        end
    endtask

    task automatic test_single;
        @(posedge clk); #1;
        model_mode = 0;
        resp_ready = 4'b0100;
        req_addr[2*ADDR_W +: ADDR_W] = 100;
        req_valid = 4'b0100;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100 || callee_start) begin
            errors++;
            $display("FAIL single_c0: got ready %b start %0d required 0100 0", req_ready, callee_start);
        end
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (!callee_start || callee_addr !== 100 || grant !== 2'd2) begin
            errors++;
            $display("FAIL single_c1: got start %0d addr %0d grant %0d required 1 100 2",
                     callee_start, callee_addr, grant);
        end
        @(negedge clk);
        checks++;
        if (!callee_ready || callee_start || resp_valid !== '0) begin
            errors++;
            $display("FAIL single_c2: got ready %0d start %0d resp %b required 1 0 0000",
                     callee_ready, callee_start, resp_valid);
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 4'b0100 || resp_data !== 42169 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL single_c3: got valid %b data %0d err %0d required 0100 42169 0",
                     resp_valid, resp_data, resp_err);
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== '0 || callee_ready) begin
            errors++;
            $display("FAIL single_c4: got valid %b ready %0d required 0000 0", resp_valid, callee_ready);
        end
    endtask

    task automatic test_backpressure;
        int c;
        bit seen;
        @(posedge clk); #1;
        model_mode = 0;
        resp_ready = '0;
        req_addr[1*ADDR_W +: ADDR_W] = 7;
        req_addr[3*ADDR_W +: ADDR_W] = 30;
        req_valid = 4'b0010;
        wait_resp(c, seen);
        checks++;
        if (!seen || resp_valid !== 4'b0010) begin
            errors++;
            $display("FAIL bp_first: got seen=%0d valid %b required 1 0010", seen, resp_valid);
        end
        req_valid  = 4'b1000;
        resp_ready = 4'b1101;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 4'b0010 || resp_data !== 42076 || req_ready !== '0 || callee_start) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid %b data %0d rdy %b start %0d required 0010 42076 0 0",
                         k, resp_valid, resp_data, req_ready, callee_start);
            end
        end
        resp_ready = 4'b0010;
        @(negedge clk);
        checks++;
        if (resp_valid !== '0 || req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL bp_release: got valid %b req_ready %b required 0000 1000", resp_valid,
                     req_ready);
        end
        resp_ready = 4'b1000;
        wait_resp(c, seen);
        checks++;
        if (!seen || resp_valid !== 4'b1000 || resp_data !== 42099) begin
            errors++;
            $display("FAIL bp_next: got seen=%0d valid %b data %0d required 1 1000 42099", seen,
                     resp_valid, resp_data);
        end
        req_valid = '0;
    endtask

    task automatic test_timeout;
        int c;
        bit seen;
        int n;
        @(posedge clk); #1;
        model_mode = 1;
        resp_ready = 4'b1111;
        req_addr[0 +: ADDR_W] = 5;
        req_valid = 4'b0001;
        wait_start(c, seen);
        req_valid = '0;
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (callee_reset) begin
                n = k;
                break;
            end
        end
        checks++;
        if (!seen || n != TIMEOUT + 1) begin
            errors++;
            $display("FAIL to_cycle: got start=%0d reset at %0d required 1 at %0d", seen, n,
                     TIMEOUT + 1);
        end
        checks++;
        if (callee_start || !callee_ready) begin
            errors++;
            $display("FAIL to_excl: got start %0d ready %0d required 0 1", callee_start, callee_ready);
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 4'b0001 || resp_err !== 1'b1 || resp_data !== 0 || callee_reset) begin
            errors++;
            $display("FAIL to_resp: got valid %b err %0d data %0d creset %0d required 0001 1 0 0",
                     resp_valid, resp_err, resp_data, callee_reset);
        end
    endtask

    task automatic test_done_no_data;
        int c;
        bit seen;
        @(posedge clk); #1;
        model_mode = 2;
        req_addr[1*ADDR_W +: ADDR_W] = 9;
        req_valid = 4'b0010;
        wait_resp(c, seen);
        req_valid = '0;
        checks++;
        if (!seen || resp_valid !== 4'b0010 || resp_err !== 1'b1) begin
            errors++;
            $display("FAIL dnd_err: got seen=%0d valid %b err %0d required 1 0010 1", seen,
                     resp_valid, resp_err);
        end
    endtask

    task automatic test_late_done;
        int c;
        bit seen;
        @(posedge clk); #1;
        model_mode = 4;
        req_addr[3*ADDR_W +: ADDR_W] = 50;
        req_valid = 4'b1000;
        wait_resp(c, seen);
        req_valid = '0;
        checks++;
        if (!seen || resp_valid !== 4'b1000 || resp_data !== 42119 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL late_done: got seen=%0d valid %b data %0d err %0d required 1 1000 42119 0",
                     seen, resp_valid, resp_data, resp_err);
        end
    endtask

    task automatic test_reset_in_wait;
        int c;
        bit seen;
        @(posedge clk); #1;
        model_mode = 3;
        req_addr[2*ADDR_W +: ADDR_W] = 77;
        req_addr[0 +: ADDR_W] = 11;
        req_valid = 4'b0100;
        wait_start(c, seen);
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (!seen || !callee_ready) begin
            errors++;
            $display("FAIL rw_wait: got start=%0d ready %0d required 1 1", seen, callee_ready);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, resp_valid, callee_start, callee_ready, callee_reset, resp_err, grant}
            !== '0 || resp_data !== 0 || callee_addr !== 0) begin
            errors++;
            $display("FAIL rw_zero: got ctrl %b data %0d addr %0d required 0", {req_ready,
                     resp_valid, callee_start, callee_ready, callee_reset, resp_err, grant},
                     resp_data, callee_addr);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_mode = 0;
        req_valid = 4'b0101;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001 || resp_valid !== '0) begin
            errors++;
            $display("FAIL rw_first: got ready %b resp %b required 0001 0000", req_ready, resp_valid);
        end
        wait_resp(c, seen);
        checks++;
        if (!seen || resp_valid !== 4'b0001 || resp_data !== 42080) begin
            errors++;
            $display("FAIL rw_resp0: got seen=%0d valid %b data %0d required 1 0001 42080", seen,
                     resp_valid, resp_data);
        end
        req_valid = 4'b0100;
        wait_resp(c, seen);
        checks++;
        if (!seen || resp_valid !== 4'b0100 || resp_data !== 42146) begin
            errors++;
            $display("FAIL rw_resp2: got seen=%0d valid %b data %0d required 1 0100 42146", seen,
                     resp_valid, resp_data);
        end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_backpressure();
        test_timeout();
        test_done_no_data();
        test_late_done();
        test_reset_in_wait();
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
